// File: rtl/morse_stream_decoder.sv
// Morse element stream to character-code decoder.
// Collects dots/dashes per character, looks up the code and queues it in a FIFO.
module morse_stream_decoder #(
  parameter int MAX_LEN    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int CODE_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_type,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              overflow,
  output logic [7:0]        err_count
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] COLLECT    = 2'd0;
  localparam logic [1:0] EMIT_CHAR  = 2'd1;
  localparam logic [1:0] EMIT_SPACE = 2'd2;

  localparam logic [CODE_W-1:0] C_SPACE = CODE_W'(26);
  localparam logic [CODE_W-1:0] C_ERR   = CODE_W'(27);

  logic [1:0]         state;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] shreg;
  logic               ovf_char;
  logic               space_pend;
  logic               last_space;

  logic [CODE_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic               push;
  logic               pop;
  logic [CODE_W-1:0]  wr_code;

  function automatic logic [CODE_W-1:0] lookup(
    input logic [LEN_W-1:0]   l,
    input logic [MAX_LEN-1:0] s
  );
    logic [4:0] v;
    int c;
    v = 5'(s);
    c = 27;
    case (int'(l))
      1: c = v[0] ? 19 : 4;
      2: case (v[1:0])
           2'd0: c = 8;
           2'd1: c = 0;
           2'd2: c = 13;
           default: c = 12;
         endcase
      3: case (v[2:0])
           3'd0: c = 18;
           3'd1: c = 20;
           3'd2: c = 17;
           3'd3: c = 22;
           3'd4: c = 3;
           3'd5: c = 10;
           3'd6: c = 6;
           default: c = 14;
         endcase
      4: case (v[3:0])
           4'd0:  c = 7;
           4'd1:  c = 21;
           4'd2:  c = 5;
           4'd4:  c = 11;
           4'd6:  c = 15;
           4'd7:  c = 9;
           4'd8:  c = 1;
           4'd9:  c = 23;
           4'd10: c = 2;
           4'd11: c = 24;
           4'd12: c = 25;
           4'd13: c = 16;
           4'd15: c = 26;
           default: c = 27;
         endcase
      5: case (v)
           5'd31: c = 28;
           5'd15: c = 29;
           5'd7:  c = 30;
           5'd3:  c = 31;
           5'd1:  c = 32;
           5'd0:  c = 33;
           5'd16: c = 34;
           5'd24: c = 35;
           5'd28: c = 36;
           5'd30: c = 37;
           default: c = 27;
         endcase
      default: c = 27;
    endcase
    return CODE_W'(c);
  endfunction

  // Two free slots keep a char+space emit pair from ever hitting a full FIFO
  assign in_ready  = (state == COLLECT) &&
                     (count <= CNT_W'(FIFO_DEPTH - 2));
  assign accept    = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign out_code  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  // FIFO write request and data from the emit states
  always_comb begin
    push    = 1'b0;
    wr_code = C_SPACE;
    case (state)
      EMIT_CHAR: begin
        push    = 1'b1;
        wr_code = ovf_char ? C_ERR : lookup(len, shreg);
      end
      EMIT_SPACE: push = 1'b1;
      default: push = 1'b0;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_code;
  end

  // FIFO pointers, occupancy and error counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && wr_code == C_ERR && err_count != 8'hff)
        err_count <= err_count + 8'd1;
    end
  end

  // Element collection and emit sequencing
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= COLLECT;
      len        <= '0;
      shreg      <= '0;
      ovf_char   <= 1'b0;
      space_pend <= 1'b0;
      last_space <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            case (in_type)
              2'd0, 2'd1: begin
                if (len < LEN_W'(MAX_LEN)) begin
                  shreg <= {shreg[MAX_LEN-2:0], in_type[0]};
                  len   <= len + LEN_W'(1);
                end else begin
                  ovf_char <= 1'b1;
                  overflow <= 1'b1;
                end
              end
              2'd2: begin
                if (len != '0) state <= EMIT_CHAR;
              end
              default: begin
                if (len != '0) begin
                  state      <= EMIT_CHAR;
                  space_pend <= 1'b1;
                end else if (!last_space) begin
                  state <= EMIT_SPACE;
                end
              end
            endcase
          end
        end
        EMIT_CHAR: begin
          len        <= '0;
          shreg      <= '0;
          ovf_char   <= 1'b0;
          last_space <= (wr_code == C_SPACE);
          state      <= space_pend ? EMIT_SPACE : COLLECT;
        end
        EMIT_SPACE: begin
          last_space <= 1'b1;
          space_pend <= 1'b0;
          state      <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
